// File: rtl/instruction_decode.sv
// instruction_decode: LEGv8 decode stage. This block contains the 32x64 register file
// with a write-back bypass, the control decoder and sign extender, the load-use stall
// and the branch flush. It drives the registered ID/EX slot that Execution consumes.
module instruction_decode #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            IfValid,
  input  logic [XLEN-1:0] IfAddress,
  input  logic [31:0]     IfInstruction,
  output logic            IfStall,
  input  logic            Flush,
  input  logic            WbRegWrite,
  input  logic [4:0]      WbReg,
  input  logic [XLEN-1:0] WbData,
  output logic            IdValid,
  output logic [XLEN-1:0] Address,
  output logic [31:0]     Instruction,
  output logic [XLEN-1:0] signExtInstr,
  output logic [XLEN-1:0] Data1,
  output logic [XLEN-1:0] Data2,
  output logic [1:0]      ALUSrc,
  output logic [1:0]      ALUOp,
  output logic            B,
  output logic            BZ,
  output logic            BNZ,
  output logic            MemWrite,
  output logic            MemRead,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            IllegalInstr
);

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LD   = 3'd2,
    CLS_ST   = 3'd3,
    CLS_B    = 3'd4,
    CLS_CBZ  = 3'd5,
    CLS_CBNZ = 3'd6,
    CLS_BAD  = 3'd7
  } cls_e;

  logic [XLEN-1:0] regs_r [NREGS];

  cls_e            cls_s;
  logic [4:0]      rn_s;
  logic [4:0]      rs2_s;
  logic            use1_s;
  logic            use2_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] rd1_s;
  logic [XLEN-1:0] rd2_s;
  logic [1:0]      alusrc_s;
  logic [1:0]      aluop_s;
  logic            b_s;
  logic            bz_s;
  logic            bnz_s;
  logic            memwrite_s;
  logic            memread_s;
  logic            memtoreg_s;
  logic            regwrite_s;
  logic            load_use_s;
  logic            issue_s;
  logic            illegal_s;

  // Classify the fetched word into one of the supported instruction formats.
  always_comb begin
    cls_s = CLS_BAD;
    casez (IfInstruction[31:21])
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: cls_s = CLS_R;
      11'b1001000100?,
      11'b1101000100?: cls_s = CLS_I;
      11'b11111000010: cls_s = CLS_LD;
      11'b11111000000: cls_s = CLS_ST;
      11'b000101?????: cls_s = CLS_B;
      11'b10110100???: cls_s = CLS_CBZ;
      11'b10110101???: cls_s = CLS_CBNZ;
      default:         cls_s = CLS_BAD;
    endcase
  end

  // Per-class controls, immediate and the source registers the instruction really reads.
  always_comb begin
    rn_s       = IfInstruction[9:5];
    rs2_s      = IfInstruction[20:16];
    use1_s     = 1'b0;
    use2_s     = 1'b0;
    imm_s      = {XLEN{1'b0}};
    alusrc_s   = 2'b00;
    aluop_s    = 2'b00;
    b_s        = 1'b0;
    bz_s       = 1'b0;
    bnz_s      = 1'b0;
    memwrite_s = 1'b0;
    memread_s  = 1'b0;
    memtoreg_s = 1'b0;
    regwrite_s = 1'b0;
    case (cls_s)
      CLS_R: begin
        use1_s     = 1'b1;
        use2_s     = 1'b1;
        aluop_s    = 2'b10;
        regwrite_s = 1'b1;
      end
      CLS_I: begin
        use1_s     = 1'b1;
        imm_s      = {{(XLEN-12){1'b0}}, IfInstruction[21:10]};
        alusrc_s   = 2'b10;
        aluop_s    = 2'b11;
        regwrite_s = 1'b1;
      end
      CLS_LD: begin
        use1_s     = 1'b1;
        imm_s      = {{(XLEN-9){IfInstruction[20]}}, IfInstruction[20:12]};
        alusrc_s   = 2'b01;
        memread_s  = 1'b1;
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      CLS_ST: begin
        use1_s     = 1'b1;
        use2_s     = 1'b1;
        rs2_s      = IfInstruction[4:0];
        imm_s      = {{(XLEN-9){IfInstruction[20]}}, IfInstruction[20:12]};
        alusrc_s   = 2'b01;
        memwrite_s = 1'b1;
      end
      CLS_B: begin
        imm_s   = {{(XLEN-26){IfInstruction[25]}}, IfInstruction[25:0]};
        aluop_s = 2'b01;
        b_s     = 1'b1;
      end
      CLS_CBZ, CLS_CBNZ: begin
        use2_s  = 1'b1;
        rs2_s   = IfInstruction[4:0];
        imm_s   = {{(XLEN-19){IfInstruction[23]}}, IfInstruction[23:5]};
        aluop_s = 2'b01;
        bz_s    = (cls_s == CLS_CBZ);
        bnz_s   = (cls_s == CLS_CBNZ);
      end
      default: begin
        imm_s = {XLEN{1'b0}};
      end
    endcase
  end

  // Register read ports: XZR reads zero, a same-cycle write-back is forwarded.
  always_comb begin
    if (rn_s == XZR) begin
      rd1_s = {XLEN{1'b0}};
    end else if (WbRegWrite && (WbReg == rn_s)) begin
      rd1_s = WbData;
    end else begin
      rd1_s = regs_r[rn_s];
    end
    if (rs2_s == XZR) begin
      rd2_s = {XLEN{1'b0}};
    end else if (WbRegWrite && (WbReg == rs2_s)) begin
      rd2_s = WbData;
    end else begin
      rd2_s = regs_r[rs2_s];
    end
  end

  // Hazard and issue decisions. Flush outranks the stall; the bubble a stall inserts
  // clears MemRead in ID/EX, so one load can stall at most one cycle.
  always_comb begin
    load_use_s = IdValid && MemRead && (Instruction[4:0] != XZR) &&
                 ((use1_s && (rn_s == Instruction[4:0])) ||
                  (use2_s && (rs2_s == Instruction[4:0])));
    IfStall    = IfValid && !Flush && load_use_s;
    issue_s    = IfValid && !Flush && !load_use_s && (cls_s != CLS_BAD);
    illegal_s  = IfValid && !Flush && (cls_s == CLS_BAD);
  end

  // Register file write port. XZR writes are dropped, and flush or stall does not block writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (WbRegWrite && (WbReg != XZR)) begin
      regs_r[WbReg] <= WbData;
    end
  end

  // ID/EX slot. Data fields are captured every cycle, and controls are masked to zero for a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IdValid      <= 1'b0;
      Address      <= {XLEN{1'b0}};
      Instruction  <= 32'd0;
      signExtInstr <= {XLEN{1'b0}};
      Data1        <= {XLEN{1'b0}};
      Data2        <= {XLEN{1'b0}};
      ALUSrc       <= 2'b00;
      ALUOp        <= 2'b00;
      B            <= 1'b0;
      BZ           <= 1'b0;
      BNZ          <= 1'b0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
      MemtoReg     <= 1'b0;
      RegWrite     <= 1'b0;
      IllegalInstr <= 1'b0;
    end else begin
      IdValid      <= issue_s;
      Address      <= IfAddress;
      Instruction  <= IfInstruction;
      signExtInstr <= imm_s;
      Data1        <= rd1_s;
      Data2        <= rd2_s;
      ALUSrc       <= issue_s ? alusrc_s : 2'b00;
      ALUOp        <= issue_s ? aluop_s : 2'b00;
      B            <= issue_s && b_s;
      BZ           <= issue_s && bz_s;
      BNZ          <= issue_s && bnz_s;
      MemWrite     <= issue_s && memwrite_s;
      MemRead      <= issue_s && memread_s;
      MemtoReg     <= issue_s && memtoreg_s;
      RegWrite     <= issue_s && regwrite_s;
      IllegalInstr <= illegal_s;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed scenarios plus randomized traffic, checked against
// a behavioural model of the decode stage (register array + field arithmetic).
module tb_instruction_decode;

  logic        clk;
  logic        rst_n;
  logic        IfValid;
  logic [63:0] IfAddress;
  logic [31:0] IfInstruction;
  logic        IfStall;
  logic        Flush;
  logic        WbRegWrite;
  logic [4:0]  WbReg;
  logic [63:0] WbData;
  logic        IdValid;
  logic [63:0] Address;
  logic [31:0] Instruction;
  logic [63:0] signExtInstr;
  logic [63:0] Data1;
  logic [63:0] Data2;
  logic [1:0]  ALUSrc;
  logic [1:0]  ALUOp;
  logic        B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite, IllegalInstr;

  instruction_decode dut (
    .clk(clk), .rst_n(rst_n), .IfValid(IfValid), .IfAddress(IfAddress),
    .IfInstruction(IfInstruction), .IfStall(IfStall), .Flush(Flush),
    .WbRegWrite(WbRegWrite), .WbReg(WbReg), .WbData(WbData), .IdValid(IdValid),
    .Address(Address), .Instruction(Instruction), .signExtInstr(signExtInstr),
    .Data1(Data1), .Data2(Data2), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .B(B), .BZ(BZ),
    .BNZ(BNZ), .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .IllegalInstr(IllegalInstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        legal;
    logic        use1;
    logic        use2;
    logic [4:0]  r2;
    logic [1:0]  alusrc;
    logic [1:0]  aluop;
    logic        b, bz, bnz, mw, mr, m2r, rw;
    logic [63:0] imm;
  } dec_t;

  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic [63:0] m_regs [32];
  logic        m_valid = 1'b0;
  logic        m_mr = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic        last_stall = 1'b0;
  logic        obs_stall = 1'b0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input longint f, input int bits);
    if (f >= (longint'(1) << (bits - 1))) f = f - (longint'(1) << bits);
    return f;
  endfunction

  function automatic dec_t model_dec(input logic [31:0] w);
    dec_t d;
    d = '0;
    if (w[31:21] == 11'b10001011000 || w[31:21] == 11'b11001011000 ||
        w[31:21] == 11'b10001010000 || w[31:21] == 11'b10101010000) begin
      d.legal = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1; d.r2 = w[20:16];
      d.aluop = 2'd2; d.rw = 1'b1;
    end else if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100) begin
      d.legal = 1'b1; d.use1 = 1'b1; d.alusrc = 2'd2; d.aluop = 2'd3; d.rw = 1'b1;
      d.imm = 64'(w[21:10]);
    end else if (w[31:21] == 11'b11111000010) begin
      d.legal = 1'b1; d.use1 = 1'b1; d.alusrc = 2'd1; d.mr = 1'b1; d.m2r = 1'b1; d.rw = 1'b1;
      d.imm = sx(longint'(w[20:12]), 9);
    end else if (w[31:21] == 11'b11111000000) begin
      d.legal = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1; d.r2 = w[4:0]; d.alusrc = 2'd1; d.mw = 1'b1;
      d.imm = sx(longint'(w[20:12]), 9);
    end else if (w[31:26] == 6'b000101) begin
      d.legal = 1'b1; d.aluop = 2'd1; d.b = 1'b1;
      d.imm = sx(longint'(w[25:0]), 26);
    end else if (w[31:24] == 8'b10110100 || w[31:24] == 8'b10110101) begin
      d.legal = 1'b1; d.use2 = 1'b1; d.r2 = w[4:0]; d.aluop = 2'd1;
      d.bz = (w[24] == 1'b0); d.bnz = (w[24] == 1'b1);
      d.imm = sx(longint'(w[23:5]), 19);
    end
    return d;
  endfunction

  function automatic logic [63:0] model_read(input logic [4:0] r, input logic we,
                                             input logic [4:0] wr, input logic [63:0] wd);
    if (r == 5'd31) return 64'd0;
    if (we && wr == r) return wd;
    return m_regs[r];
  endfunction

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 9) == 0) return 5'd31;
    return 5'($urandom_range(0, 5));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = pick_reg(); b = pick_reg(); c = pick_reg();
    case ($urandom_range(0, 9))
      0: return {11'b10001011000, a, 6'd0, b, c};
      1: return {11'b11001011000, a, 6'd0, b, c};
      2: return {($urandom_range(0, 1) == 0) ? 11'b10001010000 : 11'b10101010000, a, 6'd0, b, c};
      3: return {($urandom_range(0, 1) == 0) ? 10'b1001000100 : 10'b1101000100, 12'($urandom), b, c};
      4, 5: return {11'b11111000010, 9'($urandom), 2'b00, b, c};
      6: return {11'b11111000000, 9'($urandom), 2'b00, b, c};
      7: return {6'b000101, 26'($urandom)};
      8: return {($urandom_range(0, 1) == 0) ? 8'b10110100 : 8'b10110101, 19'($urandom), c};
      default: return $urandom;
    endcase
  endfunction

  // One decode cycle: drive inputs, check the combinational stall, then check ID/EX after the edge.
  task automatic cycle(input logic v, input logic [63:0] a, input logic [31:0] w, input logic fl,
                       input logic we, input logic [4:0] wr, input logic [63:0] wd);
    dec_t d;
    logic st, ev, eill;
    logic [63:0] e1, e2;
    @(negedge clk);
    IfValid = v; IfAddress = a; IfInstruction = w; Flush = fl;
    WbRegWrite = we; WbReg = wr; WbData = wd;
    d  = model_dec(w);
    st = !fl && v && m_valid && m_mr && (m_rd != 5'd31) &&
         ((d.use1 && w[9:5] == m_rd) || (d.use2 && d.r2 == m_rd));
    ev   = v && !fl && !st && d.legal;
    eill = v && !fl && !d.legal;
    e1   = model_read(w[9:5], we, wr, wd);
    e2   = model_read(d.r2, we, wr, wd);
    #1;
    obs_stall = IfStall;
    chk_val("IfStall", IfStall, st);
    if (we && wr != 5'd31) m_regs[wr] = wd;
    @(posedge clk);
    #1;
    chk_val("IdValid", IdValid, ev);
    chk_val("Illegal", IllegalInstr, eill);
    chk_val("ctrl", {ALUSrc, ALUOp, B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite},
            ev ? {d.alusrc, d.aluop, d.b, d.bz, d.bnz, d.mw, d.mr, d.m2r, d.rw} : 11'd0);
    if (ev) begin
      chk_val("Address", Address, a);
      chk_val("Instruction", Instruction, w);
      chk_val("signExt", signExtInstr, d.imm);
      if (d.use1) chk_val("Data1", Data1, e1);
      if (d.use2) chk_val("Data2", Data2, e2);
    end
    m_valid = ev; m_mr = ev && d.mr; m_rd = w[4:0];
    last_stall = st;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_val({tag, "_valid"}, IdValid, 64'd0);
    chk_val({tag, "_addr"}, Address, 64'd0);
    chk_val({tag, "_instr"}, Instruction, 64'd0);
    chk_val({tag, "_imm"}, signExtInstr, 64'd0);
    chk_val({tag, "_d1"}, Data1, 64'd0);
    chk_val({tag, "_d2"}, Data2, 64'd0);
    chk_val({tag, "_ctrl"}, {ALUSrc, ALUOp, B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite,
            IllegalInstr}, 64'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_valid = 1'b0; m_mr = 1'b0; m_rd = 5'd0; last_stall = 1'b0;
  endtask

  initial begin
    logic        v, fl, we;
    logic [63:0] a, wd;
    logic [31:0] w;
    logic [4:0]  wr;
    rst_n = 1'b0; IfValid = 1'b0; IfAddress = 64'd0; IfInstruction = 32'd0;
    Flush = 1'b0; WbRegWrite = 1'b0; WbReg = 5'd0; WbData = 64'd0;
    model_reset();
    #1;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // ADD X1,X3,X31 after X3 <- 0x2A
    cycle(1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 5'd3, 64'h2A);
    cycle(1'b1, 64'h100, {11'b10001011000, 5'd31, 6'd0, 5'd3, 5'd1}, 1'b0, 1'b0, 5'd0, 64'd0);
    chk_val("t2_d1", Data1, 64'h2A);
    chk_val("t2_d2", Data2, 64'd0);
    chk_val("t2_src_op", {ALUSrc, ALUOp, RegWrite}, 5'b00101);

    // SUBI X2,X4,#7 with same-cycle write X4 <- 0x99
    cycle(1'b1, 64'h104, {10'b1101000100, 12'd7, 5'd4, 5'd2}, 1'b0, 1'b1, 5'd4, 64'h99);
    chk_val("t3_d1", Data1, 64'h99);
    chk_val("t3_imm", signExtInstr, 64'd7);
    chk_val("t3_src_op", {ALUSrc, ALUOp}, 4'b1011);

    // LDUR X9,[X1,#-8] then ADD X2,X9,X3: one stall, then ADD issues
    cycle(1'b1, 64'h108, {11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd9}, 1'b0, 1'b0, 5'd0, 64'd0);
    chk_val("t4_imm", signExtInstr, 64'hFFFF_FFFF_FFFF_FFF8);
    cycle(1'b1, 64'h10C, {11'b10001011000, 5'd3, 6'd0, 5'd9, 5'd2}, 1'b0, 1'b0, 5'd0, 64'd0);
    chk_val("t4_stall", obs_stall, 64'd1);
    chk_val("t4_bubble", IdValid, 64'd0);
    cycle(1'b1, 64'h10C, {11'b10001011000, 5'd3, 6'd0, 5'd9, 5'd2}, 1'b0, 1'b0, 5'd0, 64'd0);
    chk_val("t4_nostall", obs_stall, 64'd0);
    chk_val("t4_issue", IdValid, 64'd1);

    // CBZ X7,#-1 flushed, then issued
    cycle(1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 5'd7, 64'h77);
    cycle(1'b1, 64'h110, {8'b10110100, 19'h7FFFF, 5'd7}, 1'b1, 1'b0, 5'd0, 64'd0);
    chk_val("t5_flush_stall", obs_stall, 64'd0);
    chk_val("t5_flush_valid", IdValid, 64'd0);
    cycle(1'b1, 64'h110, {8'b10110100, 19'h7FFFF, 5'd7}, 1'b0, 1'b0, 5'd0, 64'd0);
    chk_val("t5_bz", BZ, 64'd1);
    chk_val("t5_d2", Data2, 64'h77);
    chk_val("t5_imm", signExtInstr, 64'hFFFF_FFFF_FFFF_FFFF);

    // Illegal word plus write to XZR
    cycle(1'b1, 64'h114, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd31, 64'hDEAD);
    chk_val("t6_valid", IdValid, 64'd0);
    chk_val("t6_ill", IllegalInstr, 64'd1);
    cycle(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 5'd0, 64'd0);
    chk_val("t6_ill_pulse", IllegalInstr, 64'd0);
    cycle(1'b1, 64'h118, {11'b10001011000, 5'd31, 6'd0, 5'd31, 5'd1}, 1'b0, 1'b0, 5'd0, 64'd0);
    chk_val("t6_xzr", Data1, 64'd0);

    // Randomized traffic; a stalled instruction is held by fetch
    v = 1'b1; a = 64'd0; w = 32'd0;
    for (int n = 0; n < 500; n++) begin
      if (!last_stall) begin
        w = rand_instr();
        a = {$urandom, $urandom};
        v = ($urandom_range(0, 9) != 0);
      end
      fl = ($urandom_range(0, 9) == 0);
      we = 1'($urandom_range(0, 1));
      wr = pick_reg();
      wd = {$urandom, $urandom};
      cycle(v, a, w, fl, we, wr, wd);
    end

    // Asynchronous reset mid-run
    cycle(1'b1, 64'h200, {11'b10001011000, 5'd5, 6'd0, 5'd5, 5'd1}, 1'b0, 1'b1, 5'd5, 64'h55);
    @(negedge clk);
    IfValid = 1'b0; Flush = 1'b0; WbRegWrite = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 64'h204, {11'b10001011000, 5'd5, 6'd0, 5'd5, 5'd1}, 1'b0, 1'b0, 5'd0, 64'd0);
    chk_val("reset_x5", Data1, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
